// File: rtl/fifo_level_ppm_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_level_ppm_ctrl_if
//
// Bundles the control inputs and the ppm/status outputs of the FIFO-level
// rate controller.
//
//   enable     : run the control loop (low = idle, partial window discarded)
//   hold       : freeze the integrator on updates, P term stays live
//   fifo_level : input-FIFO occupancy, unsigned
//   ppm_out    : signed ppm correction presented to the resampler
//   ppm_valid  : one-cycle strobe whenever ppm_out is refreshed
//   locked     : loop settled within tolerance for enough updates
//   sat        : last update was clamped at the ppm limit
//
// master = the side driving enable/hold/fifo_level (control layer / bench)
// slave  = the controller itself
// ---------------------------------------------------------------------------
interface fifo_level_ppm_ctrl_if #(
    parameter int LEVEL_WIDTH = 11
) ();
    logic                   enable;
    logic                   hold;
    logic [LEVEL_WIDTH-1:0] fifo_level;
    logic signed [31:0]     ppm_out;
    logic                   ppm_valid;
    logic                   locked;
    logic                   sat;

    modport master (
        output enable,
        output hold,
        output fifo_level,
        input  ppm_out,
        input  ppm_valid,
        input  locked,
        input  sat
    );

    modport slave (
        input  enable,
        input  hold,
        input  fifo_level,
        output ppm_out,
        output ppm_valid,
        output locked,
        output sat
    );
endinterface

// File: rtl/fifo_level_ppm_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_level_ppm_ctrl
//
// Closed-loop rate controller feeding the resampler's ppm input. The FIFO
// fill level is registered once, summed over a window of 2^WINDOW_LOG2
// cycles, averaged, and compared with TARGET_LEVEL. A PI loop on that error
// produces a clamped signed ppm correction. Lock and saturation status are
// reported alongside.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   ctl  : fifo_level_ppm_ctrl_if.slave
//            in : enable, hold, fifo_level
//            out: ppm_out, ppm_valid, locked, sat
//
// Timing: with the first enabled IDLE cycle as cycle 0, fifo_level values
// from cycles 0..N-1 form the first window (one register of input delay),
// the update is computed on cycle N+1 and the registered results appear on
// cycle N+2. Subsequent updates follow every N+1 cycles.
// ---------------------------------------------------------------------------
module fifo_level_ppm_ctrl #(
    parameter int                 LEVEL_WIDTH  = 11,
    parameter int                 TARGET_LEVEL = 512,
    parameter int                 WINDOW_LOG2  = 10,
    parameter int                 KP_SHIFT     = 4,
    parameter int                 KI_SHIFT     = 8,
    parameter int                 INT_WIDTH    = 24,
    parameter logic signed [31:0] PPM_LIMIT    = 32'sd200000,
    parameter int                 LOCK_TOL     = 4,
    parameter int                 LOCK_COUNT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_level_ppm_ctrl_if.slave  ctl
);

    // -----------------------------------------------------------------------
    // Derived widths and constants
    // -----------------------------------------------------------------------
    localparam int ACC_W  = LEVEL_WIDTH + WINDOW_LOG2;  // sum of N levels never overflows
    localparam int ERR_W  = LEVEL_WIDTH + 1;
    localparam int INT_W1 = INT_WIDTH + 1;              // one guard bit for saturation
    localparam int RAW_W  = 34;
    localparam int LCNT_W = $clog2(LOCK_COUNT + 1);

    localparam logic signed [ERR_W-1:0]  TARGET_S   = ERR_W'(TARGET_LEVEL);
    localparam logic signed [ERR_W-1:0]  LOCK_TOL_S = ERR_W'(LOCK_TOL);
    localparam logic signed [INT_W1-1:0] INT_MAX    = $signed({2'b00, {(INT_WIDTH-1){1'b1}}});
    localparam logic signed [INT_W1-1:0] INT_MIN    = -INT_MAX;
    localparam logic signed [RAW_W-1:0]  LIMIT_POS  = RAW_W'(PPM_LIMIT);
    localparam logic signed [RAW_W-1:0]  LIMIT_NEG  = -LIMIT_POS;
    localparam logic [WINDOW_LOG2-1:0]   CNT_LAST   = {WINDOW_LOG2{1'b1}};
    localparam logic [LCNT_W-1:0]        LCNT_MAX   = LCNT_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                   state_q;
    logic [LEVEL_WIDTH-1:0]   level_q;
    logic [ACC_W-1:0]         acc_q;
    logic [WINDOW_LOG2-1:0]   cnt_q;
    logic signed [INT_WIDTH-1:0] integ_q;
    logic [LCNT_W-1:0]        lock_cnt_q;
    logic signed [31:0]       ppm_q;
    logic                     ppm_valid_q;
    logic                     locked_q;
    logic                     sat_q;

    // -----------------------------------------------------------------------
    // Update datapath: only consumed while in UPDATE, evaluated every cycle
    // -----------------------------------------------------------------------
    logic [LEVEL_WIDTH-1:0]      avg;
    logic signed [ERR_W-1:0]     err;
    logic signed [ERR_W-1:0]     err_abs;
    logic                        in_tol;
    logic signed [INT_W1-1:0]    integ_sum;
    logic signed [INT_W1-1:0]    integ_lim;
    logic signed [INT_WIDTH-1:0] integ_d;
    logic signed [RAW_W-1:0]     p_term;
    logic signed [RAW_W-1:0]     i_term;
    logic signed [RAW_W-1:0]     raw;
    logic signed [RAW_W-1:0]     raw_lim;
    logic signed [31:0]          ppm_d;
    logic                        sat_d;
    logic [LCNT_W-1:0]           lock_cnt_d;

    always_comb begin
        // Truncating average: drop the low WINDOW_LOG2 bits of the window sum.
        avg = acc_q[ACC_W-1:WINDOW_LOG2];
        err = $signed({1'b0, avg}) - TARGET_S;

        // Integrator with symmetric saturation; hold leaves it untouched.
        integ_sum = INT_W1'(integ_q) + INT_W1'(err);
        if (integ_sum > INT_MAX) begin
            integ_lim = INT_MAX;
        end else if (integ_sum < INT_MIN) begin
            integ_lim = INT_MIN;
        end else begin
            integ_lim = integ_sum;
        end
        integ_d = ctl.hold ? integ_q : integ_lim[INT_WIDTH-1:0];

        // PI sum at 34 bits: the P term alone can reach 2^(ERR_W-1+KP_SHIFT).
        p_term = RAW_W'(err) <<< KP_SHIFT;
        i_term = RAW_W'(integ_d >>> KI_SHIFT);
        raw    = p_term + i_term;

        sat_d = 1'b0;
        if (raw > LIMIT_POS) begin
            raw_lim = LIMIT_POS;
            sat_d   = 1'b1;
        end else if (raw < LIMIT_NEG) begin
            raw_lim = LIMIT_NEG;
            sat_d   = 1'b1;
        end else begin
            raw_lim = raw;
        end
        ppm_d = raw_lim[31:0];

        // Lock counter: any out-of-tolerance update restarts the count.
        err_abs = err[ERR_W-1] ? -err : err;
        in_tol  = (err_abs <= LOCK_TOL_S);
        if (!in_tol) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q == LCNT_MAX) begin
            lock_cnt_d = lock_cnt_q;
        end else begin
            lock_cnt_d = lock_cnt_q + LCNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            integ_q     <= '0;
            lock_cnt_q  <= '0;
            ppm_q       <= '0;
            ppm_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            // The level is always registered first so the accumulator never
            // sees the asynchronous-producer side combinationally.
            level_q     <= ctl.fifo_level;
            ppm_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (ctl.enable) begin
                        state_q <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (!ctl.enable) begin
                        // Partial window is dropped; IDLE clears it as well.
                        state_q <= IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= acc_q + ACC_W'(level_q);
                        cnt_q <= cnt_q + WINDOW_LOG2'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= UPDATE;
                        end
                    end
                end

                UPDATE: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (!ctl.enable) begin
                        // Pre-empted: outputs, integrator and lock stay as they were.
                        state_q <= IDLE;
                    end else begin
                        integ_q     <= integ_d;
                        ppm_q       <= ppm_d;
                        sat_q       <= sat_d;
                        lock_cnt_q  <= lock_cnt_d;
                        locked_q    <= (lock_cnt_d == LCNT_MAX);
                        ppm_valid_q <= 1'b1;
                        state_q     <= ACCUM;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ctl.ppm_out   = ppm_q;
    assign ctl.ppm_valid = ppm_valid_q;
    assign ctl.locked    = locked_q;
    assign ctl.sat       = sat_q;

endmodule

// File: tb/tb_fifo_level_ppm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_level_ppm_ctrl
//
// Drives the rate controller with directed scenarios and then randomized
// level/enable/hold/reset traffic. A timeline model derived from the window
// rules predicts the outputs, which are compared on every cycle.
// ---------------------------------------------------------------------------
module tb_fifo_level_ppm_ctrl;

    localparam int     LW   = 11;
    localparam int     WL2  = 8;
    localparam int     N    = 1 << WL2;
    localparam int     KP   = 4;
    localparam int     KI   = 2;
    localparam int     INTW = 24;
    localparam int     TGT  = 512;
    localparam int     TOL  = 4;
    localparam int     LCNT = 4;
    localparam longint LIM  = 8000;
    localparam longint IMAX = (64'sd1 <<< (INTW - 1)) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_level_ppm_ctrl_if #(.LEVEL_WIDTH(LW)) bus ();

    fifo_level_ppm_ctrl #(
        .LEVEL_WIDTH (LW),
        .TARGET_LEVEL(TGT),
        .WINDOW_LOG2 (WL2),
        .KP_SHIFT    (KP),
        .KI_SHIFT    (KI),
        .INT_WIDTH   (INTW),
        .PPM_LIMIT   (32'sd8000),
        .LOCK_TOL    (TOL),
        .LOCK_COUNT  (LCNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctl(bus)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    bit     check_en = 1'b0;
    longint cyc = 0;

    // Model state: m_t counts cycles since the enabled run started (-1 = idle).
    longint             m_t = -1;
    longint             m_sum = 0;
    longint             m_integ = 0;
    int                 m_lock = 0;
    logic signed [31:0] e_ppm = '0;
    bit                 e_valid = 1'b0;
    bit                 e_locked = 1'b0;
    bit                 e_sat = 1'b0;

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Window j uses the levels of run cycles j*(N+1) .. j*(N+1)+N-1; its
    // update happens on run cycle (j+1)*(N+1) and is visible one edge later.
    always @(posedge clk) begin : model
        longint t_n, sum_n, integ_n, avg, err, raw, abs_err;
        int     lc_n;
        bit     upd;
        cyc = cyc + 1;
        upd     = 1'b0;
        t_n     = m_t;
        sum_n   = m_sum;
        integ_n = m_integ;
        lc_n    = m_lock;
        if (rst) begin
            m_t      <= -1;
            m_sum    <= 0;
            m_integ  <= 0;
            m_lock   <= 0;
            e_ppm    <= '0;
            e_valid  <= 1'b0;
            e_locked <= 1'b0;
            e_sat    <= 1'b0;
        end else begin
            if (!bus.enable) begin
                t_n   = -1;
                sum_n = 0;
            end else begin
                if (t_n < 0) begin
                    t_n   = 0;
                    sum_n = 0;
                end else begin
                    t_n = t_n + 1;
                end
                if (t_n > 0 && (t_n % (N + 1)) == 0) begin
                    upd = 1'b1;
                    avg = sum_n / N;
                    err = avg - TGT;
                    if (!bus.hold) begin
                        integ_n = integ_n + err;
                        if (integ_n > IMAX)  integ_n = IMAX;
                        if (integ_n < -IMAX) integ_n = -IMAX;
                    end
                    raw = err * (64'sd1 <<< KP) + (integ_n >>> KI);
                    if (raw > LIM) begin
                        e_ppm <= 32'(LIM);
                        e_sat <= 1'b1;
                    end else if (raw < -LIM) begin
                        e_ppm <= 32'(-LIM);
                        e_sat <= 1'b1;
                    end else begin
                        e_ppm <= 32'(raw);
                        e_sat <= 1'b0;
                    end
                    abs_err = (err < 0) ? -err : err;
                    if (abs_err <= TOL) lc_n = (lc_n < LCNT) ? lc_n + 1 : LCNT;
                    else                lc_n = 0;
                    e_locked <= (lc_n == LCNT);
                    sum_n = 0;
                end
                if ((t_n % (N + 1)) < N) sum_n = sum_n + longint'(bus.fifo_level);
            end
            e_valid <= upd;
            m_t     <= t_n;
            m_sum   <= sum_n;
            m_integ <= integ_n;
            m_lock  <= lc_n;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            n_cmp++;
            if (bus.ppm_out !== e_ppm || bus.ppm_valid !== e_valid ||
                bus.locked !== e_locked || bus.sat !== e_sat) begin
                n_bad++;
                $display("FAIL outputs cycle %0d: got ppm=%0d valid=%0b locked=%0b sat=%0b, expected ppm=%0d valid=%0b locked=%0b sat=%0b",
                         cyc, bus.ppm_out, bus.ppm_valid, bus.locked, bus.sat,
                         e_ppm, e_valid, e_locked, e_sat);
            end
            if (bus.ppm_valid === 1'b1)
                $display("pulse cycle %0d: ppm_out=%0d locked=%0b sat=%0b",
                         cyc, bus.ppm_out, bus.locked, bus.sat);
        end
    end

    task automatic wait_pulse(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.ppm_valid !== 1'b1 && waited < 4 * N);
        check("pulse_seen", bus.ppm_valid, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ppm", bus.ppm_out, 0);
        check("rst_locked", bus.locked, 0);
    endtask

    initial begin : stim
        int     w;
        int     base;
        int     lvl;
        bit     seen;
        logic signed [31:0] p0;
        int     exp_t2 [3] = '{130, 132, 134};

        rst = 1'b1;
        bus.enable = 1'b0;
        bus.hold = 1'b0;
        bus.fifo_level = LW'(512);
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check("reset_ppm", bus.ppm_out, 0);
        check("reset_valid", bus.ppm_valid, 0);
        check("reset_locked", bus.locked, 0);
        check("reset_sat", bus.sat, 0);
        rst = 1'b0;

        // On-target level: zero correction, lock on the 4th update.
        bus.fifo_level = LW'(512);
        bus.enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wait_pulse(w);
            check("t1_spacing", w, (i == 1) ? N + 2 : N + 1);
            check("t1_ppm", bus.ppm_out, 0);
            check("t1_locked", bus.locked, (i >= 4) ? 1 : 0);
        end

        // Constant +8 error with KI_SHIFT=2: P=128 plus a growing I term.
        do_reset();
        bus.fifo_level = LW'(520);
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_pulse(w);
            check("t2_ppm", bus.ppm_out, exp_t2[i]);
            check("t2_locked", bus.locked, 0);
            check("t2_sat", bus.sat, 0);
        end

        // Empty FIFO: -8192-128 clamps at -8000.
        do_reset();
        bus.fifo_level = LW'(0);
        bus.enable = 1'b1;
        wait_pulse(w);
        check("t3_ppm", bus.ppm_out, -8000);
        check("t3_sat", bus.sat, 1);

        // Lock, lose it on a step, regain after four in-tolerance updates.
        do_reset();
        bus.fifo_level = LW'(512);
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) wait_pulse(w);
        check("t4_locked_initial", bus.locked, 1);
        bus.fifo_level = LW'(530);
        wait_pulse(w);
        check("t4_locked_step", bus.locked, 0);
        bus.fifo_level = LW'(512);
        for (int i = 1; i <= 4; i++) begin
            wait_pulse(w);
            check("t4_relock", bus.locked, (i == 4) ? 1 : 0);
        end

        // Enable dropped mid-window: nothing emitted, output held.
        repeat (100) @(negedge clk);
        bus.enable = 1'b0;
        p0 = bus.ppm_out;
        seen = 1'b0;
        repeat (2 * N) begin
            @(negedge clk);
            if (bus.ppm_valid === 1'b1) seen = 1'b1;
        end
        check("t5_no_pulse", seen, 0);
        check("t5_ppm_held", bus.ppm_out, p0);
        bus.enable = 1'b1;
        wait_pulse(w);
        check("t5_latency", w, N + 2);

        // Hold after one normal update keeps the I term frozen at 8>>>2.
        do_reset();
        bus.fifo_level = LW'(520);
        bus.enable = 1'b1;
        wait_pulse(w);
        check("t6_first", bus.ppm_out, 130);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_pulse(w);
            check("t6_held", bus.ppm_out, 130);
        end
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_ppm", bus.ppm_out, 0);
        check("t6_rst_valid", bus.ppm_valid, 0);
        check("t6_rst_locked", bus.locked, 0);
        check("t6_rst_sat", bus.sat, 0);
        rst = 1'b0;
        bus.hold = 1'b0;

        // Randomized traffic, checked cycle by cycle against the model.
        base = 512;
        bus.enable = 1'b1;
        for (int c = 0; c < 40000; c++) begin
            if ($urandom_range(0, 399) == 0)
                base = ($urandom_range(0, 1) == 0) ? 512 : int'($urandom_range(0, 1024));
            lvl = base + int'($urandom_range(0, 16)) - 8;
            if (lvl < 0) lvl = 0;
            if (lvl > 1024) lvl = 1024;
            bus.fifo_level = LW'(lvl);
            bus.hold = ($urandom_range(0, 3) == 0);
            if (bus.enable) begin
                if ($urandom_range(0, 2999) == 0) bus.enable = 1'b0;
            end else begin
                if ($urandom_range(0, 19) == 0) bus.enable = 1'b1;
            end
            rst = ($urandom_range(0, 19999) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.enable = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
